// File: rtl/ervp_multi_timer.sv
// NUM_CH-channel APB compare timer (one-shot or drift-free periodic) on a shared microsecond time base.
// Zero-wait APB with rpready tied to 1, so it never applies backpressure; interrupts are asserted 1 cycle after the match edge.
module ervp_multi_timer #(
  parameter int BW_ADDR    = 8,
  parameter int BW_DATA    = 32,
  parameter int NUM_CH     = 4,
  parameter int BW_COUNTER = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rpsel,
  input  logic               rpenable,
  input  logic [BW_ADDR-1:0] rpaddr,
  input  logic               rpwrite,
  input  logic [BW_DATA-1:0] rpwdata,
  output logic [BW_DATA-1:0] rprdata,
  output logic               rpready,
  output logic               rpslverr,
  input  logic               tick_1us,
  output logic [NUM_CH-1:0]  timer_interrupt,
  output logic               timer_interrupt_any
);

  logic [BW_COUNTER-1:0] count_q, count_d;
  logic [BW_COUNTER-1:0] cmp_q    [NUM_CH];
  logic [BW_COUNTER-1:0] cmp_d    [NUM_CH];
  logic [BW_COUNTER-1:0] period_q [NUM_CH];
  logic [BW_COUNTER-1:0] period_d [NUM_CH];
  logic [BW_COUNTER-1:0] per_eff  [NUM_CH];
  logic [BW_COUNTER-1:0] remain   [NUM_CH];
  logic [NUM_CH-1:0]     en_q, en_d, periodic_q, periodic_d, irq_en_q, irq_en_d, pend_q, pend_d;
  logic [NUM_CH-1:0]     hit, ctrl_wr, period_wr, stat_wr;

  logic       access, top_ok, glob_ok, ch_ok;
  logic [3:0] blk, ch_idx;
  logic [1:0] reg_sel;

  // Reset masks any in-flight access so it reads 0 with no error.
  assign access  = rpsel & rpenable & ~rst;
  assign blk     = rpaddr[7:4];
  assign reg_sel = rpaddr[3:2];
  assign ch_idx  = blk - 4'd1;
  assign top_ok  = ((rpaddr >> 8) == '0) && (rpaddr[1:0] == 2'b00);
  assign glob_ok = top_ok && (blk == 4'd0) && !reg_sel[1];
  assign ch_ok   = top_ok && (blk != 4'd0) && ({28'd0, blk} <= 32'(NUM_CH));
  assign rpready = 1'b1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign per_eff[g] = (period_q[g] == '0) ? BW_COUNTER'(1) : period_q[g];
    assign hit[g]     = en_q[g] & (count_q == cmp_q[g]) & ~ctrl_wr[g];
    assign remain[g]  = en_q[g] ? (cmp_q[g] - count_q) : '0;
  end

  always_comb begin
    rprdata   = '0;
    rpslverr  = 1'b0;
    ctrl_wr   = '0;
    period_wr = '0;
    stat_wr   = '0;
    if (access) begin
      if (glob_ok) begin
        if (rpwrite) rpslverr = 1'b1;
        else if (reg_sel == 2'd0) rprdata[BW_COUNTER-1:0] = count_q;
        else rprdata[NUM_CH-1:0] = pend_q;
      end else if (ch_ok) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) begin
            case (reg_sel)
              2'd0: begin
                if (rpwrite) ctrl_wr[i] = 1'b1;
                else rprdata[2:0] = {irq_en_q[i], periodic_q[i], en_q[i]};
              end
              2'd1: begin
                if (rpwrite) period_wr[i] = 1'b1;
                else rprdata[BW_COUNTER-1:0] = period_q[i];
              end
              2'd2: begin
                if (rpwrite) stat_wr[i] = 1'b1;
                else rprdata[0] = pend_q[i];
              end
              default: begin
                if (rpwrite) rpslverr = 1'b1;
                else rprdata[BW_COUNTER-1:0] = remain[i];
              end
            endcase
          end
        end
      end else begin
        rpslverr = 1'b1;
      end
    end
  end

  always_comb begin
    count_d    = (tick_1us && (|en_q)) ? count_q + BW_COUNTER'(1) : count_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    pend_d     = pend_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_d[i]    = cmp_q[i];
      period_d[i] = period_q[i];
      if (ctrl_wr[i]) begin
        en_d[i]       = rpwdata[0];
        periodic_d[i] = rpwdata[1];
        irq_en_d[i]   = rpwdata[2];
        if (rpwdata[0]) cmp_d[i] = count_q + per_eff[i];
      end else if (hit[i]) begin
        // Reload from the old compare value so periodic channels never drift.
        if (periodic_q[i]) cmp_d[i] = cmp_q[i] + per_eff[i];
        else en_d[i] = 1'b0;
      end
      if (period_wr[i]) period_d[i] = rpwdata[BW_COUNTER-1:0];
      pend_d[i] = hit[i] | (pend_q[i] & ~(stat_wr[i] & rpwdata[0]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      en_q       <= '0;
      periodic_q <= '0;
      irq_en_q   <= '0;
      pend_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i]    <= '0;
        period_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i]    <= cmp_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  assign timer_interrupt     = pend_q & irq_en_q;
  assign timer_interrupt_any = |timer_interrupt;

endmodule

// File: tb/tb_ervp_multi_timer.sv
// Directed bench for ervp_multi_timer: 32-bit instance plus an 8-bit instance for wrap-around.
module tb_ervp_multi_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rpsel = 1'b0, rpsel8 = 1'b0, rpenable = 1'b0, rpwrite = 1'b0;
  logic [7:0]  rpaddr = '0;
  logic [31:0] rpwdata = '0;
  logic        tick = 1'b0, tick8 = 1'b0;
  logic [31:0] rprdata, rprdata8;
  logic        rpready, rpready8, rpslverr, rpslverr8;
  logic [3:0]  timer_interrupt, timer_interrupt8;
  logic        timer_interrupt_any, timer_interrupt_any8;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  ervp_multi_timer dut (
    .clk(clk), .rst(rst), .rpsel(rpsel), .rpenable(rpenable), .rpaddr(rpaddr),
    .rpwrite(rpwrite), .rpwdata(rpwdata), .rprdata(rprdata), .rpready(rpready),
    .rpslverr(rpslverr), .tick_1us(tick), .timer_interrupt(timer_interrupt),
    .timer_interrupt_any(timer_interrupt_any)
  );

  ervp_multi_timer #(.BW_COUNTER(8)) dut8 (
    .clk(clk), .rst(rst), .rpsel(rpsel8), .rpenable(rpenable), .rpaddr(rpaddr),
    .rpwrite(rpwrite), .rpwdata(rpwdata), .rprdata(rprdata8), .rpready(rpready8),
    .rpslverr(rpslverr8), .tick_1us(tick8), .timer_interrupt(timer_interrupt8),
    .timer_interrupt_any(timer_interrupt_any8)
  );

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apb_write(input bit w8, input logic [7:0] a, input logic [31:0] d, output logic e);
    @(posedge clk); #1;
    rpaddr = a; rpwdata = d; rpwrite = 1'b1; rpenable = 1'b0;
    if (w8) rpsel8 = 1'b1; else rpsel = 1'b1;
    @(posedge clk); #1 rpenable = 1'b1;
    #3 e = w8 ? rpslverr8 : rpslverr;
    @(posedge clk); #1;
    rpsel = 1'b0; rpsel8 = 1'b0; rpenable = 1'b0; rpwrite = 1'b0;
  endtask

  // Tick lands in the setup cycle so the access phase coincides with the match cycle.
  task automatic apb_write_tick(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(posedge clk); #1;
    rpaddr = a; rpwdata = d; rpwrite = 1'b1; rpenable = 1'b0; rpsel = 1'b1; tick = 1'b1;
    @(posedge clk); #1 rpenable = 1'b1; tick = 1'b0;
    #3 e = rpslverr;
    @(posedge clk); #1;
    rpsel = 1'b0; rpenable = 1'b0; rpwrite = 1'b0;
  endtask

  task automatic apb_read(input bit w8, input logic [7:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    rpaddr = a; rpwrite = 1'b0; rpenable = 1'b0;
    if (w8) rpsel8 = 1'b1; else rpsel = 1'b1;
    @(posedge clk); #1 rpenable = 1'b1;
    #3 d = w8 ? rprdata8 : rprdata;
    e = w8 ? rpslverr8 : rpslverr;
    @(posedge clk); #1;
    rpsel = 1'b0; rpsel8 = 1'b0; rpenable = 1'b0;
  endtask

  task automatic pulse_tick(input bit w8, input int gap);
    @(posedge clk); #1;
    if (w8) tick8 = 1'b1; else tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; tick8 = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (timer_interrupt !== 4'h0 || timer_interrupt_any !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b/%b expected 0000/0", timer_interrupt, timer_interrupt_any); end
    n_checks++; if (rprdata !== 32'h0 || rpslverr !== 1'b0 || rpready !== 1'b1 || rpready8 !== 1'b1) begin n_fail++; $display("FAIL reset_bus: got rd=%h err=%b rdy=%b/%b expected 0/0/1/1", rprdata, rpslverr, rpready, rpready8); end
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_count: got %h err=%b expected 0", rd, err); end
    apb_read(0, 8'h10, rd, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl0: got %h expected 0", rd); end
    n_checks++; if (timer_interrupt8 !== 4'h0) begin n_fail++; $display("FAIL reset_irq8: got %b expected 0000", timer_interrupt8); end
  endtask

  task automatic test_oneshot();
    do_reset();
    apb_write(0, 8'h14, 32'd5, err);
    apb_write(0, 8'h10, 32'h5, err);
    repeat (4) pulse_tick(0, 2);
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL oneshot_early: got %b expected 0000", timer_interrupt); end
    pulse_tick(0, 2);
    n_checks++; if (timer_interrupt !== 4'b0001 || timer_interrupt_any !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b/%b expected 0001/1", timer_interrupt, timer_interrupt_any); end
    apb_read(0, 8'h10, rd, err);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL oneshot_ctrl: got %h expected 4", rd); end
    repeat (3) pulse_tick(0, 2);
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL oneshot_count_hold: got %0d expected 5", rd); end
    apb_read(0, 8'h18, rd, err);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL oneshot_stat: got %h expected 1", rd); end
  endtask

  task automatic test_periodic();
    do_reset();
    apb_write(0, 8'h14, 32'd1000, err);
    apb_write(0, 8'h10, 32'h3, err);
    repeat (10) pulse_tick(0, 0);
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd10) begin n_fail++; $display("FAIL per_count10: got %0d expected 10", rd); end
    apb_write(0, 8'h24, 32'd3, err);
    apb_write(0, 8'h20, 32'h7, err);
    repeat (2) pulse_tick(0, 0);
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL per_early: got %b expected 0000", timer_interrupt); end
    pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'b0010) begin n_fail++; $display("FAIL per_hit13: got %b expected 0010", timer_interrupt); end
    apb_read(0, 8'h2C, rd, err);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL per_remain13: got %0d expected 3", rd); end
    pulse_tick(0, 0);
    apb_read(0, 8'h2C, rd, err);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL per_remain14: got %0d expected 2", rd); end
    apb_write(0, 8'h28, 32'h1, err);
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL per_w1c: got %b expected 0000", timer_interrupt); end
    pulse_tick(0, 0);
    apb_write_tick(8'h28, 32'h1, err);
    n_checks++; if (timer_interrupt !== 4'b0010) begin n_fail++; $display("FAIL per_set_wins: got %b expected 0010", timer_interrupt); end
    apb_read(0, 8'h2C, rd, err);
    n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL per_remain16: got %0d expected 3", rd); end
    apb_write(0, 8'h28, 32'h1, err);
    repeat (2) pulse_tick(0, 0);
    pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'b0010) begin n_fail++; $display("FAIL per_hit19: got %b expected 0010", timer_interrupt); end
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd19) begin n_fail++; $display("FAIL per_count19: got %0d expected 19", rd); end
  endtask

  task automatic test_wrap();
    do_reset();
    apb_write(1, 8'h44, 32'd200, err);
    apb_write(1, 8'h40, 32'h3, err);
    repeat (250) pulse_tick(1, 0);
    apb_read(1, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd250) begin n_fail++; $display("FAIL wrap_count250: got %0d expected 250", rd); end
    apb_write(1, 8'h14, 32'd10, err);
    apb_write(1, 8'h10, 32'h7, err);
    apb_read(1, 8'h1C, rd, err);
    n_checks++; if (rd !== 32'd10) begin n_fail++; $display("FAIL wrap_remain_arm: got %0d expected 10", rd); end
    repeat (9) pulse_tick(1, 0);
    n_checks++; if (timer_interrupt8 !== 4'h0) begin n_fail++; $display("FAIL wrap_early: got %b expected 0000", timer_interrupt8); end
    pulse_tick(1, 1);
    n_checks++; if (timer_interrupt8 !== 4'b0001 || timer_interrupt_any8 !== 1'b1) begin n_fail++; $display("FAIL wrap_hit4: got %b/%b expected 0001/1", timer_interrupt8, timer_interrupt_any8); end
    apb_read(1, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd4) begin n_fail++; $display("FAIL wrap_count4: got %0d expected 4", rd); end
    apb_read(1, 8'h04, rd, err);
    n_checks++; if (rd !== 32'h9) begin n_fail++; $display("FAIL wrap_pendsum: got %h expected 9", rd); end
    apb_write(1, 8'h18, 32'h1, err);
    repeat (9) pulse_tick(1, 0);
    n_checks++; if (timer_interrupt8 !== 4'h0) begin n_fail++; $display("FAIL wrap_early14: got %b expected 0000", timer_interrupt8); end
    pulse_tick(1, 1);
    n_checks++; if (timer_interrupt8 !== 4'b0001) begin n_fail++; $display("FAIL wrap_hit14: got %b expected 0001", timer_interrupt8); end
    apb_read(1, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd14) begin n_fail++; $display("FAIL wrap_count14: got %0d expected 14", rd); end
  endtask

  task automatic test_multi();
    do_reset();
    apb_write(0, 8'h14, 32'd4, err);
    apb_write(0, 8'h34, 32'd4, err);
    apb_write(0, 8'h10, 32'h5, err);
    apb_write(0, 8'h30, 32'h5, err);
    repeat (3) pulse_tick(0, 0);
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL multi_early: got %b expected 0000", timer_interrupt); end
    pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'b0101 || timer_interrupt_any !== 1'b1) begin n_fail++; $display("FAIL multi_hit: got %b/%b expected 0101/1", timer_interrupt, timer_interrupt_any); end
    apb_read(0, 8'h04, rd, err);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL multi_pendsum: got %h expected 5", rd); end
    apb_write(0, 8'h30, 32'h0, err);
    n_checks++; if (timer_interrupt !== 4'b0001 || timer_interrupt_any !== 1'b1) begin n_fail++; $display("FAIL multi_mask: got %b/%b expected 0001/1", timer_interrupt, timer_interrupt_any); end
  endtask

  task automatic test_edges();
    do_reset();
    apb_write(0, 8'h44, 32'd0, err);
    apb_write(0, 8'h40, 32'h7, err);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL p0_no_tick: got %b expected 0000", timer_interrupt); end
    pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'b1000) begin n_fail++; $display("FAIL p0_hit1: got %b expected 1000", timer_interrupt); end
    apb_read(0, 8'h4C, rd, err);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL p0_remain: got %0d expected 1", rd); end
    apb_write(0, 8'h48, 32'h1, err);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL p0_not_every_cycle: got %b expected 0000", timer_interrupt); end
    pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'b1000) begin n_fail++; $display("FAIL p0_hit2: got %b expected 1000", timer_interrupt); end
    apb_write(0, 8'h24, 32'd2, err);
    apb_write(0, 8'h20, 32'h5, err);
    pulse_tick(0, 0);
    apb_write_tick(8'h20, 32'h5, err);
    n_checks++; if (err !== 1'b0 || timer_interrupt[1] !== 1'b0) begin n_fail++; $display("FAIL ctrl_wins: got err=%b irq1=%b expected 0/0", err, timer_interrupt[1]); end
    apb_read(0, 8'h28, rd, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ctrl_wins_stat: got %h expected 0", rd); end
    apb_read(0, 8'h2C, rd, err);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL ctrl_rearm_remain: got %0d expected 2", rd); end
    apb_write(0, 8'h00, 32'h55, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ro_write_err: got %b expected 1", err); end
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'd4 || err !== 1'b0) begin n_fail++; $display("FAIL ro_write_nochg: got %0d err=%b expected 4/0", rd, err); end
    apb_read(0, 8'h50, rd, err);
    n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got err=%b rd=%h expected 1/0", err, rd); end
    apb_write(0, 8'h2C, 32'h77, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL remain_write_err: got %b expected 1", err); end
    apb_read(0, 8'h2C, rd, err);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL remain_nochg: got %0d expected 2", rd); end
    apb_read(0, 8'h08, rd, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL gap_read_err: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apb_write(0, 8'h14, 32'd2, err);
    apb_write(0, 8'h10, 32'h7, err);
    pulse_tick(0, 0);
    pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_hit: got %b expected 0001", timer_interrupt); end
    @(posedge clk); #1;
    rpsel = 1'b1; rpenable = 1'b1; rpaddr = 8'h00; rpwrite = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (rprdata !== 32'h0 || rpslverr !== 1'b0) begin n_fail++; $display("FAIL mid_bus: got rd=%h err=%b expected 0/0", rprdata, rpslverr); end
    @(posedge clk); #1;
    n_checks++; if (timer_interrupt !== 4'h0 || timer_interrupt_any !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b/%b expected 0000/0", timer_interrupt, timer_interrupt_any); end
    rst = 1'b0; rpsel = 1'b0; rpenable = 1'b0;
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", rd); end
    repeat (3) pulse_tick(0, 1);
    n_checks++; if (timer_interrupt !== 4'h0) begin n_fail++; $display("FAIL mid_no_hit: got %b expected 0000", timer_interrupt); end
    apb_read(0, 8'h00, rd, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_count_hold: got %0d expected 0", rd); end
    apb_read(0, 8'h10, rd, err);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl: got %h expected 0", rd); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_multi();
    test_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
